// File: rtl/fetch_controller.sv
// Instruction fetch front end: one outstanding 16-bit read, a one-entry output slot plus a skid entry.
// States: IDLE wait for enable | REQ issue and collect reads | DRAIN finish a stale read and drop its data.
module fetch_controller #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [15:0] redirect_addr_i,
  output logic        mem_req_o,
  output logic [15:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_data_high_i,
  input  logic [7:0]  mem_data_low_i,
  output logic        instr_valid_o,
  output logic [15:0] instr_o,
  output logic [15:0] instr_pc_o,
  output logic [15:0] pc_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [15:0] PC_INIT = {RESET_PC[15:1], 1'b0};

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        mem_req_q, mem_req_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic        slot_valid_q, slot_valid_d;
  logic [15:0] slot_instr_q, slot_instr_d;
  logic [15:0] slot_pc_q, slot_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [15:0] skid_instr_q, skid_instr_d;
  logic [15:0] skid_pc_q, skid_pc_d;

  logic        ack_fire;
  logic        ack_take;
  logic        consume;
  logic        slot_free;
  logic        can_issue;
  logic [15:0] fetched;
  logic [15:0] pc_inc;

  assign ack_fire  = mem_req_q & mem_ack_i;
  assign ack_take  = ack_fire & (state_q == ST_REQ) & ~redirect_valid_i;
  assign consume   = slot_valid_q & ~stall_i;
  assign slot_free = ~slot_valid_q | consume;
  assign can_issue = enable_i & ~skid_valid_q & slot_free;
  assign fetched   = {mem_data_high_i, mem_data_low_i};
  assign pc_inc    = pc_q + 16'd2;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    slot_valid_d = slot_valid_q;
    slot_instr_d = slot_instr_q;
    slot_pc_d    = slot_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    // Slot refills from the skid first so program order is kept.
    if (slot_free) begin
      if (skid_valid_q) begin
        slot_valid_d = 1'b1;
        slot_instr_d = skid_instr_q;
        slot_pc_d    = skid_pc_q;
        skid_valid_d = ack_take;
        if (ack_take) begin
          skid_instr_d = fetched;
          skid_pc_d    = mem_addr_q;
        end
      end else if (ack_take) begin
        slot_valid_d = 1'b1;
        slot_instr_d = fetched;
        slot_pc_d    = mem_addr_q;
      end else begin
        slot_valid_d = 1'b0;
      end
    end else if (ack_take) begin
      skid_valid_d = 1'b1;
      skid_instr_d = fetched;
      skid_pc_d    = mem_addr_q;
    end

    if (ack_take) begin
      pc_d = pc_inc;
    end

    case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!mem_req_q || ack_fire) begin
          mem_req_d = 1'b0;
          if (can_issue) begin
            mem_req_d  = 1'b1;
            mem_addr_d = ack_fire ? pc_inc : pc_q;
          end
        end
      end
      ST_DRAIN: begin
        if (ack_fire) begin
          mem_req_d = 1'b0;
          state_d   = ST_REQ;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    // A redirect flushes everything; a read still in flight must finish before the new pc is used.
    if (redirect_valid_i) begin
      pc_d         = {redirect_addr_i[15:1], 1'b0};
      slot_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      if (state_q == ST_REQ) begin
        if (mem_req_q && !mem_ack_i) begin
          state_d    = ST_DRAIN;
          mem_req_d  = 1'b1;
          mem_addr_d = mem_addr_q;
        end else begin
          mem_req_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      pc_q         <= PC_INIT;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 16'h0000;
      slot_valid_q <= 1'b0;
      slot_instr_q <= 16'h0000;
      slot_pc_q    <= 16'h0000;
      skid_valid_q <= 1'b0;
      skid_instr_q <= 16'h0000;
      skid_pc_q    <= 16'h0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      slot_valid_q <= slot_valid_d;
      slot_instr_q <= slot_instr_d;
      slot_pc_q    <= slot_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign mem_req_o     = mem_req_q;
  assign mem_addr_o    = mem_addr_q;
  assign instr_valid_o = slot_valid_q;
  assign instr_o       = slot_instr_q;
  assign instr_pc_o    = slot_pc_q;
  assign pc_o          = pc_q;

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, SHALL be the PC value loaded on reset; bit 0 is ignored and treated as 0.
REQ-002 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 reset  in  1  SHALL be asynchronous and active-low: reset=0 forces the reset state immediately, independent of clk.
REQ-004 enable  in  1  SHALL gate issue of new memory requests; an outstanding request still completes when enable=0.
REQ-005 stall  in  1  SHALL be decode back-pressure; the held instruction is consumed in any cycle with instr_valid=1 and stall=0.
REQ-006 redirect_valid  in  1  SHALL be a one-cycle request to restart fetch at redirect_addr.
REQ-007 redirect_addr  in  16  SHALL be the new fetch address, sampled when redirect_valid=1.
REQ-008 mem_req  out  1  SHALL request an instruction read from memory.
REQ-009 mem_addr  out  16  SHALL be the read address, valid while mem_req=1.
REQ-010 mem_ack  in  1  SHALL complete the request in the cycle it is 1 while mem_req=1.
REQ-011 mem_data_high, mem_data_low  in  8 each  SHALL be the instruction bytes, valid with mem_ack.
REQ-012 instr_valid  out  1  SHALL flag that instr/instr_pc hold a fetched instruction.
REQ-013 instr  out  16  SHALL be {mem_data_high, mem_data_low} of the fetched instruction.
REQ-014 instr_pc  out  16  SHALL be the address instr was fetched from.
REQ-015 pc  out  16  SHALL be the next fetch address.

Function
REQ-016 States SHALL be IDLE, REQ, DRAIN; IDLE->REQ when enable=1.
REQ-017 Storage SHALL be one output slot (instr/instr_pc/instr_valid) plus one skid entry; order SHALL be preserved, skid drains into the slot on consumption.
REQ-018 In REQ, a new request SHALL be raised only if enable=1, the skid is empty, and (instr_valid=0 or stall=0).
REQ-019 Once raised, mem_req and mem_addr SHALL stay stable until the cycle mem_ack=1; zero-wait ack (ack in the first req cycle) SHALL be supported.
REQ-020 On ack in REQ: data SHALL enter the slot if free or being consumed this cycle, else the skid; pc SHALL become pc+2, wrapping 16'hFFFE->16'h0000.
REQ-021 With mem_ack tied 1, stall=0 and enable=1, one instruction SHALL be delivered per cycle; latency request-to-instr_valid is 1 cycle after ack.
REQ-022 redirect_valid SHALL have priority over all events: next cycle instr_valid=0, skid empty, pc=redirect_addr with bit 0 cleared.
REQ-023 Redirect while a request is outstanding and not acked that cycle SHALL enter DRAIN: mem_req/mem_addr held at the old address until ack, data discarded, then REQ at the new pc.
REQ-024 Redirect in the same cycle as ack SHALL discard that data and go to REQ.
REQ-025 Redirect in DRAIN SHALL update pc only; DRAIN continues.
REQ-026 mem_ack while mem_req=0 SHALL be ignored.

Reset
REQ-027 On reset=0: state=IDLE, pc=RESET_PC, mem_req=0, mem_addr=0, instr_valid=0, instr=0, instr_pc=0, skid empty, asynchronously.
REQ-028 First request SHALL be raised no earlier than the second rising clk edge after reset rises.

Verification
REQ-029 Reset release, enable=1, ack tied 1, stall=0 -> mem_addr 0000,0002,0004 on consecutive cycles; instr_valid=1 from the cycle after first ack with instr_pc=0000.
REQ-030 Ack delayed 3 cycles -> mem_req and mem_addr=0000 stable for all 3 wait cycles, single instr delivered.
REQ-031 stall=1 for 4 cycles, ack tied 1 -> slot holds 0000, skid holds 0002, mem_req=0; stall=0 -> 0000,0002,0004 delivered in order, none lost or duplicated.
REQ-032 Redirect to 0100 while request at 0006 is outstanding -> DRAIN until ack, 0006 data never shows instr_valid, next request 0100.
REQ-033 RESET_PC=FFFC -> fetch addresses FFFC, FFFE, 0000.
REQ-034 reset=0 mid-request with mem_req=1 and instr_valid=1 -> both 0 before the next clk edge; restart at RESET_PC.
